cosine_job_arbiter: RTL and testbench

Round-robin scheduler that shares one cosine evaluation unit between NREQ independent requesters. It captures one requester's operands, pulses the unit's start, waits for its ready with a timeout guard, and returns the result to the granted requester. It sits between the requester blocks and the unit's start / x / y / ans / ans_ready ports.

---
 rtl/cosine_job_arbiter_if.sv | 32 +++
 rtl/cosine_job_arbiter.sv | 117 +++++++++++
 tb/tb_cosine_job_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cosine_job_arbiter_if.sv
// Requester-side and cosine-unit-side signals of the cosine job arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding logic.
interface cosine_job_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int X_W   = 16,
    parameter int Y_W   = 8,
    parameter int ANS_W = 16
);
    logic [NREQ-1:0]     req;
    logic [NREQ*X_W-1:0] req_x;
    logic [NREQ*Y_W-1:0] req_y;
    logic [NREQ-1:0]     req_ack;
    logic [NREQ-1:0]     rsp_valid;
    logic [ANS_W-1:0]    rsp_ans;
    logic                rsp_err;
    logic                busy;
    logic                cos_start;
    logic [X_W-1:0]      cos_x;
    logic [Y_W-1:0]      cos_y;
    logic [ANS_W-1:0]    cos_ans;
    logic                cos_ans_ready;

    modport slave (
        input  req, req_x, req_y, cos_ans, cos_ans_ready,
        output req_ack, rsp_valid, rsp_ans, rsp_err, busy, cos_start, cos_x, cos_y
    );

    modport master (
        output req, req_x, req_y, cos_ans, cos_ans_ready,
        input  req_ack, rsp_valid, rsp_ans, rsp_err, busy, cos_start, cos_x, cos_y
    );
endinterface

// File: rtl/cosine_job_arbiter.sv
// Round-robin scheduler sharing one cosine unit between NREQ requesters:
// grant, capture operands, pulse start, wait for a fresh ready (or time out), respond.
module cosine_job_arbiter #(
    parameter int NREQ    = 4,
    parameter int X_W     = 16,
    parameter int Y_W     = 8,
    parameter int ANS_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input logic                  clk,
    input logic                  rst,
    cosine_job_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [IDX_W-1:0] r_last_gnt;
    logic [X_W-1:0]   r_cos_x;
    logic [Y_W-1:0]   r_cos_y;
    logic             r_armed;
    logic [CNT_W-1:0] r_cnt;
    logic [ANS_W-1:0] r_rsp_ans;
    logic             r_rsp_err;

    logic             w_any;
    logic [IDX_W-1:0] w_win;
    logic [IDX_W-1:0] w_cand;
    logic [NREQ-1:0]  w_gnt_onehot;

    // Walk candidates from farthest to nearest so the one right after last_gnt wins.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        w_any  = 1'b0;
        w_win  = '0;
        w_cand = '0;
        for (int off = NREQ; off >= 1; off--) begin
            w_cand = IDX_W'((int'(r_last_gnt) + off) % NREQ);
            if (bus.req[w_cand]) begin
                w_any = 1'b1;
                w_win = w_cand;
            end
        end
    end

    assign w_gnt_onehot  = NREQ'(1) << r_gnt_idx;
    assign bus.req_ack   = (r_state == S_START) ? w_gnt_onehot : '0;
    assign bus.rsp_valid = (r_state == S_RESP)  ? w_gnt_onehot : '0;
    assign bus.cos_start = (r_state == S_START);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.cos_x     = r_cos_x;
    assign bus.cos_y     = r_cos_y;
    assign bus.rsp_ans   = r_rsp_ans;
    assign bus.rsp_err   = r_rsp_err;

    // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_gnt_idx  <= '0;
            r_last_gnt <= IDX_W'(NREQ - 1);
            r_cos_x    <= '0;
            r_cos_y    <= '0;
            r_armed    <= 1'b0;
            r_cnt      <= '0;
            r_rsp_ans  <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt_idx  <= w_win;
                        r_last_gnt <= w_win;
                        r_cos_x    <= bus.req_x[w_win*X_W +: X_W];
                        r_cos_y    <= bus.req_y[w_win*Y_W +: Y_W];
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_cnt   <= '0;
                    // A ready already high here belongs to the previous job.
                    r_armed <= ~bus.cos_ans_ready;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!bus.cos_ans_ready) begin
                        r_armed <= 1'b1;
                    end
                    if (r_armed && bus.cos_ans_ready) begin
                        r_rsp_ans <= bus.cos_ans;
                        r_rsp_err <= 1'b0;
                        r_state   <= S_RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_rsp_ans <= '0;
                        r_rsp_err <= 1'b1;
                        r_state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cosine_job_arbiter.sv
// Directed bench for cosine_job_arbiter: drives requesters and a scripted cosine unit
// on the falling edge and checks outputs there against hand-computed values.
module tb_cosine_job_arbiter;
    localparam int NREQ = 4;
    localparam int X_W = 16;
    localparam int Y_W = 8;
    localparam int ANS_W = 16;
    localparam int TIMEOUT = 8;
    localparam int MAX_WAIT = 50;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    bit   seen_ack1;
    bit   rsp_seen;

    cosine_job_arbiter_if #(.NREQ(NREQ), .X_W(X_W), .Y_W(Y_W), .ANS_W(ANS_W)) bus ();

    cosine_job_arbiter #(
        .NREQ(NREQ), .X_W(X_W), .Y_W(Y_W), .ANS_W(ANS_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        if (bus.req_ack[1]) seen_ack1 = 1'b1;
        if (bus.rsp_valid != '0) rsp_seen = 1'b1;
    endtask

    // Advances until an ack appears; n is the number of falling edges taken.
    task automatic wait_ack(output int n);
        n = 0;
        while (bus.req_ack == '0 && n < MAX_WAIT) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req = '0;
        bus.req_x = {16'hDDDD, 16'h1234, 16'hBBBB, 16'hAAAA};
        bus.req_y = {8'h44, 8'h05, 8'h22, 8'h11};
        bus.cos_ans = '0;
        bus.cos_ans_ready = 1'b0;
        step();
        step();
        n_checks++;
        if ({bus.req_ack, bus.rsp_valid, bus.busy, bus.cos_start, bus.rsp_err} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ack=%b valid=%b busy=%b start=%b err=%b, required all 0",
                     bus.req_ack, bus.rsp_valid, bus.busy, bus.cos_start, bus.rsp_err);
        end
        n_checks++;
        if ({bus.rsp_ans, bus.cos_x, bus.cos_y} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_data: ans=%h x=%h y=%h, required 0", bus.rsp_ans, bus.cos_x, bus.cos_y);
        end
        rst = 1'b1;
    endtask

    task automatic test_single_job();
        int n;
        bus.req = 4'b0100;
        wait_ack(n);
        n_checks++;
        if (n !== 1 || bus.req_ack !== 4'b0100 || bus.cos_start !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ack: edges=%0d ack=%b start=%b, required 1 0100 1", n, bus.req_ack, bus.cos_start);
        end
        n_checks++;
        if (bus.cos_x !== 16'h1234 || bus.cos_y !== 8'h05 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_operands: x=%h y=%h busy=%b, required 1234 05 1", bus.cos_x, bus.cos_y, bus.busy);
        end
        bus.req = '0;
        for (int i = 1; i <= 5; i++) begin
            step();
            n_checks++;
            if (bus.rsp_valid !== 4'b0000 || bus.cos_start !== 1'b0) begin
                n_fail++;
                $display("FAIL single_wait%0d: valid=%b start=%b, required 0000 0", i, bus.rsp_valid, bus.cos_start);
            end
        end
        bus.cos_ans = 16'h0ABC;
        bus.cos_ans_ready = 1'b1;
        step();
        n_checks++;
        if (bus.rsp_valid !== 4'b0100 || bus.rsp_ans !== 16'h0ABC || bus.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rsp: valid=%b ans=%h err=%b, required 0100 0abc 0", bus.rsp_valid, bus.rsp_ans, bus.rsp_err);
        end
        bus.cos_ans_ready = 1'b0;
        step();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0000 || bus.cos_x !== 16'h1234) begin
            n_fail++;
            $display("FAIL single_idle: busy=%b valid=%b x=%h, required 0 0000 1234", bus.busy, bus.rsp_valid, bus.cos_x);
        end
    endtask

    // Also covers back-to-back spacing: exactly one IDLE cycle between RESP and START.
    task automatic test_contention();
        int n;
        int order [3] = '{0, 1, 3};
        logic [NREQ-1:0] exp_ack;
        rst = 1'b0;
        bus.req = 4'b1011;
        step();
        rst = 1'b1;
        for (int r = 0; r < 6; r++) begin
            exp_ack = NREQ'(1) << order[r % 3];
            wait_ack(n);
            n_checks++;
            if (bus.req_ack !== exp_ack || n !== ((r == 0) ? 1 : 2)) begin
                n_fail++;
                $display("FAIL contention_grant%0d: ack=%b edges=%0d, required %b %0d",
                         r, bus.req_ack, n, exp_ack, (r == 0) ? 1 : 2);
            end
            step();
            bus.cos_ans = 16'h0100 + 16'(r);
            bus.cos_ans_ready = 1'b1;
            step();
            n_checks++;
            if (bus.rsp_valid !== exp_ack || bus.rsp_ans !== 16'h0100 + 16'(r)) begin
                n_fail++;
                $display("FAIL contention_rsp%0d: valid=%b ans=%h, required %b %h",
                         r, bus.rsp_valid, bus.rsp_ans, exp_ack, 16'h0100 + 16'(r));
            end
            bus.cos_ans_ready = 1'b0;
        end
        bus.req = '0;
        step();
    endtask

    task automatic test_timeout();
        int n;
        bus.req = 4'b0001;
        wait_ack(n);
        n_checks++;
        if (bus.req_ack !== 4'b0001 || n >= MAX_WAIT) begin
            n_fail++;
            $display("FAIL timeout_ack: ack=%b edges=%0d, required 0001 within %0d", bus.req_ack, n, MAX_WAIT);
        end
        bus.req = '0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            step();
            n_checks++;
            if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_wait%0d: valid=%b busy=%b, required 0000 1", i, bus.rsp_valid, bus.busy);
            end
        end
        bus.req = 4'b0100;
        step();
        n_checks++;
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_err !== 1'b1 || bus.rsp_ans !== 16'h0000) begin
            n_fail++;
            $display("FAIL timeout_rsp: valid=%b err=%b ans=%h, required 0001 1 0000", bus.rsp_valid, bus.rsp_err, bus.rsp_ans);
        end
        wait_ack(n);
        n_checks++;
        if (bus.req_ack !== 4'b0100 || n !== 2) begin
            n_fail++;
            $display("FAIL timeout_next_ack: ack=%b edges=%0d, required 0100 2", bus.req_ack, n);
        end
        bus.req = '0;
        step();
        bus.cos_ans = 16'h2468;
        bus.cos_ans_ready = 1'b1;
        step();
        n_checks++;
        if (bus.rsp_valid !== 4'b0100 || bus.rsp_err !== 1'b0 || bus.rsp_ans !== 16'h2468) begin
            n_fail++;
            $display("FAIL timeout_next_rsp: valid=%b err=%b ans=%h, required 0100 0 2468", bus.rsp_valid, bus.rsp_err, bus.rsp_ans);
        end
        bus.cos_ans_ready = 1'b0;
        step();
    endtask

    task automatic test_stale_ready();
        int n;
        bus.cos_ans = 16'h1111;
        bus.cos_ans_ready = 1'b1;
        bus.req = 4'b0010;
        wait_ack(n);
        n_checks++;
        if (bus.req_ack !== 4'b0010 || n >= MAX_WAIT) begin
            n_fail++;
            $display("FAIL stale_ack: ack=%b edges=%0d, required 0010", bus.req_ack, n);
        end
        bus.req = '0;
        step();
        step();
        n_checks++;
        if (bus.rsp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL stale_not_accepted: valid=%b ans=%h, required 0000", bus.rsp_valid, bus.rsp_ans);
        end
        bus.cos_ans_ready = 1'b0;
        step();
        step();
        bus.cos_ans = 16'h7FFF;
        bus.cos_ans_ready = 1'b1;
        step();
        n_checks++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_ans !== 16'h7FFF || bus.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_rsp: valid=%b ans=%h err=%b, required 0010 7fff 0", bus.rsp_valid, bus.rsp_ans, bus.rsp_err);
        end
        bus.cos_ans_ready = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_wait();
        int n;
        bus.req = 4'b1011;
        wait_ack(n);
        n_checks++;
        if (bus.req_ack !== 4'b1000) begin
            n_fail++;
            $display("FAIL midrst_pre_grant: ack=%b, required 1000", bus.req_ack);
        end
        step();
        rsp_seen = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.req_ack, bus.rsp_valid, bus.busy, bus.cos_start, bus.rsp_err} !== 11'd0 ||
            {bus.rsp_ans, bus.cos_x, bus.cos_y} !== 40'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: ack=%b valid=%b busy=%b start=%b x=%h y=%h ans=%h, required all 0",
                     bus.req_ack, bus.rsp_valid, bus.busy, bus.cos_start, bus.cos_x, bus.cos_y, bus.rsp_ans);
        end
        step();
        rst = 1'b1;
        wait_ack(n);
        n_checks++;
        if (bus.req_ack !== 4'b0001 || rsp_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_regrant: ack=%b rsp_seen=%b, required 0001 0", bus.req_ack, rsp_seen);
        end
        bus.req = '0;
        step();
        bus.cos_ans = 16'h0F0F;
        bus.cos_ans_ready = 1'b1;
        step();
        n_checks++;
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_ans !== 16'h0F0F) begin
            n_fail++;
            $display("FAIL midrst_rsp: valid=%b ans=%h, required 0001 0f0f", bus.rsp_valid, bus.rsp_ans);
        end
        bus.cos_ans_ready = 1'b0;
        step();
    endtask

    task automatic test_late_drop();
        int n;
        seen_ack1 = 1'b0;
        bus.req = 4'b0001;
        wait_ack(n);
        n_checks++;
        if (bus.req_ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL late_ack0: ack=%b, required 0001", bus.req_ack);
        end
        bus.req = '0;
        step();
        bus.req = 4'b0010;
        step();
        bus.req = '0;
        bus.cos_ans = 16'h5555;
        bus.cos_ans_ready = 1'b1;
        step();
        n_checks++;
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_ans !== 16'h5555) begin
            n_fail++;
            $display("FAIL late_rsp0: valid=%b ans=%h, required 0001 5555", bus.rsp_valid, bus.rsp_ans);
        end
        bus.cos_ans_ready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        n_checks++;
        if (seen_ack1 !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL late_drop: seen_ack1=%b busy=%b, required 0 0", seen_ack1, bus.busy);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        seen_ack1 = 1'b0;
        rsp_seen = 1'b0;
        test_reset();
        test_single_job();
        test_contention();
        test_timeout();
        test_stale_ready();
        test_reset_mid_wait();
        test_late_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
